uart_tx_fifo2: RTL and testbench

Parametrised UART transmitter with a valid/ready byte input, a one-word holding register and a shift register. It generates its own baud timing from the system clock and sends frames back-to-back with no idle gap. Data width, parity mode and stop-bit count are set by parameters. It sits between the byte-producing logic and the serial TX pin.

---
 rtl/uart_tx_fifo2.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo2.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo2.sv
// UART transmitter with a valid/ready byte input, a one-word holding register (THR)
// in front of the shift register (TSR). Frames go out back-to-back with no idle gap.
module uart_tx_fifo2 #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_data,
  output logic              tx_status,
  output logic              tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] tsr_q, tsr_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic              thr_full_q, thr_full_d;
  logic              par_q, par_d;
  logic              done_q, done_d;
  logic              tx_data_q, tx_data_d;
  logic              status_q, status_d;

  logic              hs, baud_wrap, load;
  logic [DATA_W-1:0] load_w;

  function automatic logic par_of(input logic [DATA_W-1:0] w);
    return (PARITY == 1) ? ~^w : ^w;
  endfunction

  assign hs = tx_valid & ~thr_full_q;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    tsr_d      = tsr_q;
    par_d      = par_q;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    done_d     = 1'b0;
    load       = 1'b0;
    load_w     = dataIn;
    baud_wrap  = (baud_q == BAUD_LAST);

    if (state_q != S_IDLE) baud_d = baud_wrap ? '0 : baud_q + 1'b1;
    // Any accept while the shifter is busy lands in THR; end-of-frame may promote it below.
    if (hs && state_q != S_IDLE) begin
      thr_d      = dataIn;
      thr_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE:  if (hs) load = 1'b1;
      S_START: if (baud_wrap) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (baud_wrap) begin
        tsr_d = tsr_q >> 1;
        if (bit_q == DATA_LAST) begin
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      S_PAR: if (baud_wrap) begin
        state_d = S_STOP;
        bit_d   = '0;
      end
      S_STOP: if (baud_wrap) begin
        if (bit_q == STOP_LAST) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          bit_d   = '0;
          if (thr_full_q) begin
            load       = 1'b1;
            load_w     = thr_q;
            thr_full_d = 1'b0;
          end else if (hs) begin
            load       = 1'b1;
            thr_full_d = 1'b0;
          end
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d = S_START;
      tsr_d   = load_w;
      par_d   = par_of(load_w);
      baud_d  = '0;
      bit_d   = '0;
    end
  end

  // Line and busy flag follow the state register one cycle later.
  always_comb begin
    tx_data_d = 1'b1;
    case (state_q)
      S_START: tx_data_d = 1'b0;
      S_DATA:  tx_data_d = tsr_q[0];
      S_PAR:   tx_data_d = par_q;
      default: tx_data_d = 1'b1;
    endcase
    status_d = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      tsr_q      <= '0;
      thr_q      <= '0;
      thr_full_q <= 1'b0;
      par_q      <= 1'b0;
      done_q     <= 1'b0;
      tx_data_q  <= 1'b1;
      status_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      tsr_q      <= tsr_d;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      par_q      <= par_d;
      done_q     <= done_d;
      tx_data_q  <= tx_data_d;
      status_q   <= status_d;
    end
  end

  assign tx_ready  = ~thr_full_q;
  assign tx_data   = tx_data_q;
  assign tx_status = status_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_fifo2.sv
// Directed bench for uart_tx_fifo2: 8N1, 8E1 and 7O2 instances sharing clock, reset and data bus.
module tb_uart_tx_fifo2;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] din = '0;
  logic [2:0] vld = '0;
  logic [2:0] rdy, txd, st, dn;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo2 #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .dataIn(din[7:0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx_data(txd[0]), .tx_status(st[0]), .tx_done(dn[0]));
  uart_tx_fifo2 #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .dataIn(din[7:0]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx_data(txd[1]), .tx_status(st[1]), .tx_done(dn[1]));
  uart_tx_fifo2 #(.DATA_W(7), .CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .dataIn(din[6:0]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx_data(txd[2]), .tx_status(st[2]), .tx_done(dn[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected line bits: start, data LSB first, optional parity, stop bits.
  task automatic build(input logic [8:0] d, input int dw, input int par, input int sb,
                       output logic [15:0] bits, output int nb);
    logic p;
    p = 1'b0;
    bits = '1;
    bits[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < dw; i++) begin
      bits[nb] = d[i];
      p ^= d[i];
      nb++;
    end
    if (par != 0) begin
      bits[nb] = (par == 1) ? ~p : p;
      nb++;
    end
    for (int i = 0; i < sb; i++) begin
      bits[nb] = 1'b1;
      nb++;
    end
  endtask

  task automatic frame(input int u, input logic [8:0] d, input int dw, input int par,
                       input int sb, input string tag);
    logic [15:0] bits;
    int nb;
    build(d, dw, par, sb, bits, nb);
    chk({tag, " ready"}, rdy[u], 1);
    din = d; vld[u] = 1'b1;
    tick(1);                                  // handshake edge N
    vld[u] = 1'b0; din = 9'h1AA;
    tick(1);                                  // N+1
    chk({tag, " status"}, st[u], 1);
    chk({tag, " start"}, txd[u], 0);
    tick(1);                                  // N+2
    for (int k = 0; k < nb; k++) begin
      chk($sformatf("%s bit%0d", tag, k), txd[u], bits[k]);
      if (k < nb - 1) tick(C);
    end
    tick(C - 3);                              // N+F-1
    chk({tag, " done early"}, dn[u], 0);
    tick(1);                                  // N+F
    chk({tag, " done"}, dn[u], 1);
    chk({tag, " line end"}, txd[u], 1);
    tick(1);
    chk({tag, " done width"}, dn[u], 0);
    chk({tag, " idle status"}, st[u], 0);
    chk({tag, " idle line"}, txd[u], 1);
  endtask

  // Three 8N1 frames on u0 with tx_valid held; optional dataIn churn while not ready.
  task automatic run3(input logic [8:0] d0, input logic [8:0] d1, input logic [8:0] d2,
                      input bit toggle, input string tag);
    logic [15:0] b0, b1, b2;
    int nb, f, idx, fr, bi;
    logic e;
    build(d0, 8, 0, 1, b0, nb);
    build(d1, 8, 0, 1, b1, nb);
    build(d2, 8, 0, 1, b2, nb);
    f = nb * C;
    din = d0; vld[0] = 1'b1;
    tick(1);                                  // N
    chk({tag, " ready after first"}, rdy[0], 1);
    din = d1;
    tick(1);                                  // N+1
    chk({tag, " ready after second"}, rdy[0], 0);
    din = toggle ? 9'h0E7 : d2;
    tick(1);
    for (int c = 2; c <= 3 * f + 1; c++) begin
      if ((c - 2) % C == 0) begin
        idx = (c - 2) / C; fr = idx / nb; bi = idx % nb;
        e = (fr == 0) ? b0[bi] : (fr == 1) ? b1[bi] : b2[bi];
        chk($sformatf("%s f%0d bit%0d", tag, fr, bi), txd[0], e);
      end
      if (c % f == 0) chk($sformatf("%s done@%0d", tag, c), dn[0], 1);
      if (c % f == 1) chk($sformatf("%s done low@%0d", tag, c), dn[0], 0);
      if (toggle && c < f) din = 9'(c * 37);
      if (c == f - 1) chk({tag, " ready held low"}, rdy[0], 0);
      if (c == f) begin
        chk({tag, " ready rises"}, rdy[0], 1);
        din = d2;
      end
      if (c == f + 1) begin
        chk({tag, " third accepted"}, rdy[0], 0);
        vld[0] = 1'b0;
      end
      if (c > f + 1) din = 9'(c * 11);
      if (c == 3 * f + 1) begin
        chk({tag, " end status"}, st[0], 0);
        chk({tag, " end line"}, txd[0], 1);
      end
      tick(1);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #3;
    chk("reset line", txd, 3'b111);
    chk("reset ready", rdy, 3'b111);
    chk("reset status", st, 3'b000);
    chk("reset done", dn, 3'b000);
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("post reset line", txd, 3'b111);

    frame(0, 9'h0A5, 8, 0, 1, "8N1 A5");
    frame(1, 9'h007, 8, 2, 1, "8E1 07");
    frame(1, 9'h003, 8, 2, 1, "8E1 03");
    frame(2, 9'h07F, 7, 1, 2, "7O2 7F");

    run3(9'h055, 9'h0AA, 9'h00F, 1'b0, "b2b");
    tick(3);
    run3(9'h012, 9'h034, 9'h056, 1'b1, "gate");
    tick(3);

    // Reset during data bit 3 of 0xC3 with 0x11 waiting in THR.
    din = 9'h0C3; vld[0] = 1'b1;
    tick(1);                                  // N
    din = 9'h011;
    tick(1);                                  // N+1
    chk("rst thr full", rdy[0], 0);
    vld[0] = 1'b0;
    tick(16);                                 // N+17, data bit 3 of 0xC3 = 0
    chk("rst pre line", txd[0], 0);
    #2 rst = 1'b1;
    #1;
    chk("rst line", txd[0], 1);
    chk("rst ready", rdy[0], 1);
    chk("rst status", st[0], 0);
    chk("rst done", dn[0], 0);
    tick(2);
    chk("rst held done", dn[0], 0);
    rst = 1'b0;
    tick(1);
    chk("rst release status", st[0], 0);
    chk("rst release line", txd[0], 1);
    frame(0, 9'h03C, 8, 0, 1, "after rst 3C");
    tick(C * 3);
    chk("no stale frame status", st[0], 0);
    chk("no stale frame line", txd[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
